// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// stage and the data (MEM) stage. One access in flight at a time.
// Data requests win by default; a saturating starvation counter forces an
// instruction grant after STARVE_MAX back-to-back data grants while a fetch
// is waiting.
//
//   state | meaning
//   IDLE  | no access in flight; arbitrate and latch the winner's command
//   BUSY  | command held on m_*; waiting for m_ready
//   RESP  | owner's ack pulses for this one cycle; nothing is sampled
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  // shared memory port
  output logic        m_req,
  output logic        m_we,
  output logic [1:0]  m_mode,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  // Counter wide enough to hold STARVE_MAX itself.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  // Word access in the data-memory mode encoding; fetches are always words.
  localparam logic [1:0] MODE_WORD = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             owner_data;   // 1: data port owns the access, 0: fetch
  logic             grant_i;
  logic             grant_d;
  logic             complete;

  assign starve_hit = (starve_cnt == STARVE_LIMIT);

  // Next-state logic and the one-cycle grant/complete strobes.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || starve_hit)) begin
          grant_i    = 1'b1;
          state_next = BUSY;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // m_ready is only meaningful here; elsewhere it is ignored.
        if (m_ready) begin
          complete   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight access on the floor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory command register: loaded on grant, frozen through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_mode  <= 2'b00;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
    end else if (grant_i) begin
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_mode  <= MODE_WORD;
      m_addr  <= i_addr;
      m_wdata <= 32'h0;
    end else if (grant_d) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_mode  <= d_mode;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (complete) begin
      m_req   <= 1'b0;
    end
  end

  // Owner flag remembers who the in-flight access belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_data <= 1'b0;
    end else if (grant_i) begin
      owner_data <= 1'b0;
    end else if (grant_d) begin
      owner_data <= 1'b1;
    end
  end

  // Starvation counter: counts data grants that passed over a waiting fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_i || !i_req) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt < STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Read data capture into the owner's register; stores leave d_rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
    end else if (complete) begin
      if (!owner_data) begin
        i_rdata <= m_rdata;
      end else if (!m_we) begin
        d_rdata <= m_rdata;
      end
    end
  end

  // Ack pulses are set on the BUSY->RESP edge, so they cover exactly RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
    end else begin
      i_ack <= complete && !owner_data;
      d_ack <= complete && owner_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with hand-computed
// expectations. Inputs change and outputs are sampled at the falling edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [1:0]  m_mode;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  int n_cmp;
  int n_err;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_mode  (d_mode),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_mode  (m_mode),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] last_i;
    logic [31:0] last_d;
    logic [31:0] rd;
    logic        exp_d;

    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_mode  = 2'b00;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    m_rdata = 32'h0;
    m_ready = 1'b0;
    tick();
    tick();

    // reset state
    check_val("rst_m_req",   32'(m_req),   32'h0);
    check_val("rst_m_addr",  m_addr,       32'h0);
    check_val("rst_m_wdata", m_wdata,      32'h0);
    check_val("rst_acks",    32'({i_ack, d_ack}), 32'h0);
    check_val("rst_i_rdata", i_rdata,      32'h0);
    check_val("rst_d_rdata", d_rdata,      32'h0);
    rst = 1'b0;
    tick();

    // single fetch, m_ready in first BUSY cycle
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    tick();
    check_val("f1_m_req",   32'(m_req),  32'h1);
    check_val("f1_m_addr",  m_addr,      32'h0000_0100);
    check_val("f1_m_we",    32'(m_we),   32'h0);
    check_val("f1_m_mode",  32'(m_mode), 32'h0);
    check_val("f1_ack_early", 32'(i_ack), 32'h0);
    m_ready = 1'b1;
    m_rdata = 32'h2408_0005;
    tick();
    check_val("f1_i_ack",   32'(i_ack),  32'h1);
    check_val("f1_d_ack",   32'(d_ack),  32'h0);
    check_val("f1_m_req_off", 32'(m_req), 32'h0);
    check_val("f1_i_rdata", i_rdata,     32'h2408_0005);
    i_req   = 1'b0;
    m_ready = 1'b0;
    tick();
    check_val("f1_ack_once", 32'(i_ack), 32'h0);
    // stray m_ready while idle must not do anything
    m_ready = 1'b1;
    m_rdata = 32'h5555_AAAA;
    tick();
    check_val("idle_rdy_ack",  32'({i_ack, d_ack}), 32'h0);
    check_val("idle_rdy_mreq", 32'(m_req), 32'h0);
    check_val("idle_rdy_rd",   i_rdata,    32'h2408_0005);
    m_ready = 1'b0;
    tick();

    // simultaneous store and fetch: data first, then fetch
    i_req   = 1'b1;
    i_addr  = 32'h0000_0200;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_mode  = 2'b01;
    d_addr  = 32'h0000_0040;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    check_val("st_m_we",    32'(m_we),   32'h1);
    check_val("st_m_addr",  m_addr,      32'h0000_0040);
    check_val("st_m_wdata", m_wdata,     32'hDEAD_BEEF);
    check_val("st_m_mode",  32'(m_mode), 32'h1);
    m_ready = 1'b1;
    m_rdata = 32'h1111_1111;
    tick();
    check_val("st_d_ack",   32'(d_ack),  32'h1);
    check_val("st_i_ack",   32'(i_ack),  32'h0);
    check_val("st_d_rdata", d_rdata,     32'h0);
    d_req   = 1'b0;
    m_ready = 1'b0;
    tick();
    check_val("st_idle_mreq", 32'(m_req), 32'h0);
    tick();
    check_val("st_f_m_addr",  m_addr,      32'h0000_0200);
    check_val("st_f_m_we",    32'(m_we),   32'h0);
    check_val("st_f_m_wdata", m_wdata,     32'h0);
    check_val("st_f_m_mode",  32'(m_mode), 32'h0);
    m_ready = 1'b1;
    m_rdata = 32'h8C09_0004;
    tick();
    check_val("st_f_i_ack",   32'(i_ack),  32'h1);
    check_val("st_f_d_ack",   32'(d_ack),  32'h0);
    check_val("st_f_i_rdata", i_rdata,     32'h8C09_0004);
    check_val("st_f_d_rdata", d_rdata,     32'h0);
    i_req   = 1'b0;
    m_ready = 1'b0;
    tick();

    // starvation: both requests held, expect d,d,d,d,i repeating
    last_i  = i_rdata;
    last_d  = d_rdata;
    i_req   = 1'b1;
    i_addr  = 32'h0000_0400;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_mode  = 2'b00;
    d_addr  = 32'h0000_0300;
    d_wdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      exp_d = ((k % 5) != 4);
      tick();
      check_val($sformatf("sv%0d_m_addr", k), m_addr, exp_d ? 32'h0000_0300 : 32'h0000_0400);
      rd      = 32'hA000_0000 + 32'(k);
      m_ready = 1'b1;
      m_rdata = rd;
      tick();
      if (exp_d) last_d = rd;
      else       last_i = rd;
      check_val($sformatf("sv%0d_d_ack", k), 32'(d_ack), 32'(exp_d));
      check_val($sformatf("sv%0d_i_ack", k), 32'(i_ack), 32'(!exp_d));
      check_val($sformatf("sv%0d_d_rdata", k), d_rdata, last_d);
      check_val($sformatf("sv%0d_i_rdata", k), i_rdata, last_i);
      m_ready = 1'b0;
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // slow memory, address toggled during BUSY
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    tick();
    for (int c = 1; c < 5; c++) begin
      check_val($sformatf("slow%0d_m_addr", c), m_addr, 32'h0000_0500);
      check_val($sformatf("slow%0d_m_req", c), 32'(m_req), 32'h1);
      check_val($sformatf("slow%0d_d_ack", c), 32'(d_ack), 32'h0);
      d_addr  = 32'h0000_0500 ^ (32'h1000 << c);
      d_we    = c[0];
      tick();
    end
    check_val("slow5_m_addr", m_addr, 32'h0000_0500);
    check_val("slow5_m_we", 32'(m_we), 32'h0);
    m_ready = 1'b1;
    m_rdata = 32'hCAFE_F00D;
    tick();
    check_val("slow_d_ack",   32'(d_ack), 32'h1);
    check_val("slow_d_rdata", d_rdata,    32'hCAFE_F00D);
    d_req   = 1'b0;
    d_we    = 1'b0;
    m_ready = 1'b0;
    tick();
    check_val("slow_single_ack", 32'({i_ack, d_ack}), 32'h0);

    // reset in second BUSY cycle, late m_ready afterwards
    i_req  = 1'b1;
    i_addr = 32'h0000_0600;
    tick();
    tick();
    check_val("rb_m_req_busy", 32'(m_req), 32'h1);
    rst   = 1'b1;
    i_req = 1'b0;
    #1;
    check_val("rb_m_req",   32'(m_req), 32'h0);
    check_val("rb_m_addr",  m_addr,     32'h0);
    check_val("rb_i_rdata", i_rdata,    32'h0);
    check_val("rb_d_rdata", d_rdata,    32'h0);
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    m_rdata = 32'hBADB_AD00;
    tick();
    check_val("rb_late_ack",  32'({i_ack, d_ack}), 32'h0);
    check_val("rb_late_mreq", 32'(m_req), 32'h0);
    check_val("rb_late_rd",   i_rdata,    32'h0);
    m_ready = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0700;
    tick();
    check_val("rb_next_m_req",  32'(m_req), 32'h1);
    check_val("rb_next_m_addr", m_addr,     32'h0000_0700);
    m_ready = 1'b1;
    m_rdata = 32'h1234_5678;
    tick();
    check_val("rb_next_d_ack",   32'(d_ack), 32'h1);
    check_val("rb_next_d_rdata", d_rdata,    32'h1234_5678);
    d_req   = 1'b0;
    m_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
